// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if: issue, flush and operand-lookup signals between the backend pipeline and the register scoreboard
interface reg_scoreboard_if #(
    parameter int NUM_REGS = 32,
    parameter int NUM_SRC  = 2,
    parameter int DEPTH    = 6
);
    localparam int RW = $clog2(NUM_REGS);
    localparam int SW = $clog2(DEPTH + 1);
    logic                  PIPE_ADVANCE;
    logic                  ISSUE_VALID;
    logic [RW-1:0]         RD_IN;
    logic                  TYPE_IN;
    logic                  FLUSH;
    logic [NUM_SRC*RW-1:0] RS_SEL;
    logic [NUM_SRC*SW-1:0] FWD_SEL;
    logic [NUM_SRC-1:0]    RS_TYPE;
    logic [NUM_SRC-1:0]    RS_HAZARD;
    logic                  STALL_REQ;
    modport master (
        output PIPE_ADVANCE, ISSUE_VALID, RD_IN, TYPE_IN, FLUSH, RS_SEL,
        input  FWD_SEL, RS_TYPE, RS_HAZARD, STALL_REQ
    );
    modport slave (
        input  PIPE_ADVANCE, ISSUE_VALID, RD_IN, TYPE_IN, FLUSH, RS_SEL,
        output FWD_SEL, RS_TYPE, RS_HAZARD, STALL_REQ
    );
endinterface

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register producer stage tracking with forwarding selects and RAW hazard detection
module reg_scoreboard #(
    parameter int NUM_REGS    = 32,
    parameter int NUM_SRC     = 2,
    parameter int DEPTH       = 6,
    parameter int ALU_LAT     = 2,
    parameter int LOAD_LAT    = 4,
    parameter int KILL_STAGES = 3
) (
    input logic             CLK,
    input logic             RST,
    reg_scoreboard_if.slave sb
);
    localparam int RW = $clog2(NUM_REGS);
    localparam int SW = $clog2(DEPTH + 1);
    localparam logic [SW-1:0] DEPTH_C = SW'(DEPTH);
    localparam logic [SW-1:0] KILL_C  = SW'(KILL_STAGES);
    localparam logic [SW-1:0] ALU_C   = SW'(ALU_LAT);
    localparam logic [SW-1:0] LOAD_C  = SW'(LOAD_LAT);

    if (!(ALU_LAT >= 1 && ALU_LAT <= LOAD_LAT && LOAD_LAT <= DEPTH && KILL_STAGES < DEPTH && NUM_SRC >= 1)) begin : g_bad_params
        $error("reg_scoreboard: illegal parameter combination");
    end

    logic [SW-1:0]         cnt    [2**RW];
    logic [SW-1:0]         cnt_nx [2**RW];
    logic                  kd     [2**RW];
    logic                  kd_nx  [2**RW];
    logic                  issue;
    logic [RW-1:0]         rs;
    logic [NUM_SRC*SW-1:0] fwd;
    logic [NUM_SRC-1:0]    typ;
    logic [NUM_SRC-1:0]    haz;

    assign issue = sb.PIPE_ADVANCE && sb.ISSUE_VALID && !sb.FLUSH && sb.RD_IN != '0;

    // Kill beats advance for speculative stages; the youngest issue overrides whatever survived.
    always_comb begin
        for (int r = 0; r < 2**RW; r++) begin
            cnt_nx[r] = '0;
            kd_nx[r]  = 1'b0;
        end
        for (int r = 1; r < NUM_REGS; r++) begin
            cnt_nx[r] = sb.FLUSH && cnt[r] != '0 && cnt[r] <= KILL_C ? '0 :
                        sb.PIPE_ADVANCE && cnt[r] != '0 ? (cnt[r] == DEPTH_C ? '0 : cnt[r] + 1'b1) : cnt[r];
            kd_nx[r]  = kd[r];
            if (issue && sb.RD_IN == RW'(r)) begin
                cnt_nx[r] = SW'(1);
                kd_nx[r]  = sb.TYPE_IN;
            end
        end
    end

    always_ff @(posedge CLK) begin
        for (int r = 0; r < 2**RW; r++) begin
            cnt[r] <= RST ? '0 : cnt_nx[r];
            kd[r]  <= RST ? 1'b0 : kd_nx[r];
        end
    end

    // Lookups read current state only, so a same-cycle issue is not visible yet.
    always_comb begin
        fwd = '0;
        typ = '0;
        haz = '0;
        rs  = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            rs = sb.RS_SEL[s*RW +: RW];
            if (rs != '0 && cnt[rs] != '0) begin
                fwd[s*SW +: SW] = cnt[rs];
                typ[s]          = kd[rs];
                haz[s]          = cnt[rs] < (kd[rs] ? LOAD_C : ALU_C);
            end
        end
    end

    assign sb.FWD_SEL   = fwd;
    assign sb.RS_TYPE   = typ;
    assign sb.RS_HAZARD = haz;
    assign sb.STALL_REQ = |haz;
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed and randomized scoreboard checks on a default build and a 3-port DEPTH=8 build
module tb_reg_scoreboard;
    localparam int RW  = 5;
    localparam int SW0 = 3;
    localparam int SW1 = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    reg_scoreboard_if #(.NUM_REGS(32), .NUM_SRC(2), .DEPTH(6)) if0 ();
    reg_scoreboard_if #(.NUM_REGS(32), .NUM_SRC(3), .DEPTH(8)) if1 ();

    reg_scoreboard #(.NUM_REGS(32), .NUM_SRC(2), .DEPTH(6)) u0 (.CLK(CLK), .RST(RST), .sb(if0.slave));
    reg_scoreboard #(.NUM_REGS(32), .NUM_SRC(3), .DEPTH(8)) u1 (.CLK(CLK), .RST(RST), .sb(if1.slave));

    typedef struct {
        string tag;
        int    dut;
        int    port;
        int    fwd;
        int    typ;
        int    haz;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   m_cnt [32];
    bit   m_kd  [32];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input int dut, input int port, input int fwd, input int typ, input int haz);
        exp_t e;
        e.tag = tag; e.dut = dut; e.port = port; e.fwd = fwd; e.typ = typ; e.haz = haz;
        exp_q.push_back(e);
    endtask

    task automatic score();
        exp_t e;
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.dut == 0) begin
                check({e.tag, "/fwd"}, 32'(if0.FWD_SEL[e.port*SW0 +: SW0]), e.fwd);
                check({e.tag, "/type"}, 32'(if0.RS_TYPE[e.port]), e.typ);
                check({e.tag, "/haz"}, 32'(if0.RS_HAZARD[e.port]), e.haz);
            end else begin
                check({e.tag, "/fwd"}, 32'(if1.FWD_SEL[e.port*SW1 +: SW1]), e.fwd);
                check({e.tag, "/type"}, 32'(if1.RS_TYPE[e.port]), e.typ);
                check({e.tag, "/haz"}, 32'(if1.RS_HAZARD[e.port]), e.haz);
            end
        end
    endtask

    task automatic drive0(input logic adv, input logic iv, input int rd, input logic ty, input logic fl);
        if0.PIPE_ADVANCE = adv;
        if0.ISSUE_VALID  = iv;
        if0.RD_IN        = RW'(rd);
        if0.TYPE_IN      = ty;
        if0.FLUSH        = fl;
    endtask

    task automatic drive1(input logic adv, input logic iv, input int rd, input logic ty);
        if1.PIPE_ADVANCE = adv;
        if1.ISSUE_VALID  = iv;
        if1.RD_IN        = RW'(rd);
        if1.TYPE_IN      = ty;
        if1.FLUSH        = 1'b0;
    endtask

    task automatic sel0(input int a, input int b);
        if0.RS_SEL = {RW'(b), RW'(a)};
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic model_step(input logic rst, input logic adv, input logic iv, input int rd, input logic ty, input logic fl);
        int c;
        for (int r = 0; r < 32; r++) begin
            c = m_cnt[r];
            if (rst || r == 0) c = 0;
            else if (fl && c >= 1 && c <= 3) c = 0;
            else if (adv && c != 0) c = (c == 6) ? 0 : c + 1;
            m_cnt[r] = c;
            if (rst) m_kd[r] = 1'b0;
        end
        if (!rst && adv && iv && !fl && rd != 0) begin
            m_cnt[rd] = 1;
            m_kd[rd]  = ty;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive0(1'b0, 1'b0, 0, 1'b0, 1'b0);
        drive1(1'b0, 1'b0, 0, 1'b0);
        sel0(0, 0);
        if1.RS_SEL = '0;
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        sel0(5, 7);
        if1.RS_SEL = {3{RW'(10)}};
        push("rst_p0", 0, 0, 0, 0, 0);
        push("rst_p1", 0, 1, 0, 0, 0);
        for (int p = 0; p < 3; p++) push("rst_u1", 1, p, 0, 0, 0);
        score();
        check("rst_stall", 32'(if0.STALL_REQ), 0);

        // ALU producer walks the full pipe
        sel0(5, 0);
        drive0(1'b1, 1'b1, 5, 1'b0, 1'b0);
        tick();
        drive0(1'b1, 1'b0, 0, 1'b0, 1'b0);
        push("alu_c1", 0, 0, 1, 0, 1);
        score();
        check("alu_c1_stall", 32'(if0.STALL_REQ), 1);
        tick();
        push("alu_c2", 0, 0, 2, 0, 0);
        score();
        check("alu_c2_stall", 32'(if0.STALL_REQ), 0);
        repeat (4) tick();
        push("alu_c6", 0, 0, 6, 0, 0);
        score();
        tick();
        push("alu_c7", 0, 0, 0, 0, 0);
        score();

        // Load producer on port 1
        sel0(0, 7);
        drive0(1'b1, 1'b1, 7, 1'b1, 1'b0);
        tick();
        drive0(1'b1, 1'b0, 0, 1'b0, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            push($sformatf("ld_c%0d", i), 0, 1, i, 1, (i < 4) ? 1 : 0);
            score();
            tick();
        end
        push("ld_ret", 0, 1, 0, 0, 0);
        score();

        // Hold with PIPE_ADVANCE low, ignored issue of rd=12
        sel0(3, 12);
        drive0(1'b1, 1'b1, 3, 1'b1, 1'b0);
        tick();
        drive0(1'b1, 1'b0, 0, 1'b0, 1'b0);
        tick();
        push("hold_pre", 0, 0, 2, 1, 1);
        score();
        drive0(1'b0, 1'b1, 12, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            push($sformatf("hold%0d", i), 0, 0, 2, 1, 1);
            push($sformatf("hold%0d_iss", i), 0, 1, 0, 0, 0);
            score();
        end
        drive0(1'b1, 1'b0, 0, 1'b0, 1'b0);
        tick();
        push("hold_resume", 0, 0, 3, 1, 1);
        score();
        repeat (6) tick();

        // Flush with advance and a dropped simultaneous issue
        sel0(4, 9);
        drive0(1'b1, 1'b1, 9, 1'b0, 1'b0);
        tick();
        drive0(1'b1, 1'b0, 0, 1'b0, 1'b0);
        tick();
        tick();
        drive0(1'b1, 1'b1, 4, 1'b0, 1'b0);
        tick();
        drive0(1'b1, 1'b0, 0, 1'b0, 1'b0);
        tick();
        push("fl_pre4", 0, 0, 2, 0, 0);
        push("fl_pre9", 0, 1, 5, 0, 0);
        score();
        drive0(1'b1, 1'b1, 11, 1'b0, 1'b1);
        tick();
        drive0(1'b1, 1'b0, 0, 1'b0, 1'b0);
        push("fl_rd4", 0, 0, 0, 0, 0);
        push("fl_rd9", 0, 1, 6, 0, 0);
        score();
        sel0(11, 9);
        push("fl_rd11", 0, 0, 0, 0, 0);
        score();
        tick();

        // Flush while frozen: stage KILL_STAGES dies, stage above holds
        sel0(20, 21);
        drive0(1'b1, 1'b1, 20, 1'b0, 1'b0);
        tick();
        drive0(1'b1, 1'b1, 21, 1'b0, 1'b0);
        tick();
        drive0(1'b1, 1'b0, 0, 1'b0, 1'b0);
        tick();
        tick();
        drive0(1'b0, 1'b0, 0, 1'b0, 1'b1);
        tick();
        drive0(1'b1, 1'b0, 0, 1'b0, 1'b0);
        push("flz_rd20", 0, 0, 4, 0, 0);
        push("flz_rd21", 0, 1, 0, 0, 0);
        score();
        repeat (4) tick();

        // Youngest producer wins; same-cycle read sees pre-issue state
        sel0(6, 0);
        drive0(1'b1, 1'b1, 6, 1'b0, 1'b0);
        tick();
        drive0(1'b1, 1'b0, 0, 1'b0, 1'b0);
        tick();
        tick();
        push("yw_pre", 0, 0, 3, 0, 0);
        score();
        drive0(1'b1, 1'b1, 6, 1'b1, 1'b0);
        push("yw_same_cycle", 0, 0, 3, 0, 0);
        score();
        tick();
        drive0(1'b1, 1'b0, 0, 1'b0, 1'b0);
        push("yw_new", 0, 0, 1, 1, 1);
        push("yw_r0", 0, 1, 0, 0, 0);
        score();
        check("yw_stall", 32'(if0.STALL_REQ), 1);
        repeat (7) tick();

        // Randomized traffic against a reference model
        RST = 1'b1;
        tick();
        RST = 1'b0;
        for (int r = 0; r < 32; r++) begin
            m_cnt[r] = 0;
            m_kd[r]  = 1'b0;
        end
        for (int n = 0; n < 400; n++) begin
            logic adv, iv, ty, fl, rst;
            int   rd, a, b, rs, c, stall;
            bit   hit, hz;
            adv = ($urandom_range(0, 3) != 0);
            iv  = 1'($urandom_range(0, 1));
            ty  = 1'($urandom_range(0, 1));
            fl  = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 49) == 0);
            rd  = $urandom_range(0, 7);
            a   = $urandom_range(0, 7);
            b   = $urandom_range(0, 7);
            RST = rst;
            drive0(adv, iv, rd, ty, fl);
            sel0(a, b);
            stall = 0;
            for (int p = 0; p < 2; p++) begin
                rs  = p ? b : a;
                c   = m_cnt[rs];
                hit = rs != 0 && c != 0;
                hz  = hit && c < (m_kd[rs] ? 4 : 2);
                if (hz) stall = 1;
                push($sformatf("rnd%0d_p%0d", n, p), 0, p, hit ? c : 0, hit ? int'(m_kd[rs]) : 0, int'(hz));
            end
            score();
            check($sformatf("rnd%0d_stall", n), 32'(if0.STALL_REQ), 32'(stall));
            tick();
            model_step(rst, adv, iv, rd, ty, fl);
        end
        RST = 1'b0;
        drive0(1'b0, 1'b0, 0, 1'b0, 1'b0);

        // Three-port DEPTH=8 build: identical ports, last stage, mid-flight reset
        if1.RS_SEL = {3{RW'(10)}};
        drive1(1'b1, 1'b1, 10, 1'b1);
        tick();
        drive1(1'b1, 1'b0, 0, 1'b0);
        tick();
        for (int p = 0; p < 3; p++) push($sformatf("w3_c2_p%0d", p), 1, p, 2, 1, 1);
        score();
        repeat (6) tick();
        for (int p = 0; p < 3; p++) push($sformatf("w3_c8_p%0d", p), 1, p, 8, 1, 0);
        score();
        tick();
        for (int p = 0; p < 3; p++) push($sformatf("w3_ret_p%0d", p), 1, p, 0, 0, 0);
        score();
        drive1(1'b1, 1'b1, 10, 1'b1);
        tick();
        drive1(1'b1, 1'b0, 0, 1'b0);
        tick();
        tick();
        for (int p = 0; p < 3; p++) push($sformatf("w3_c3_p%0d", p), 1, p, 3, 1, 1);
        score();
        check("w3_stall", 32'(if1.STALL_REQ), 1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        for (int p = 0; p < 3; p++) push($sformatf("w3_rst_p%0d", p), 1, p, 0, 0, 0);
        score();
        check("w3_rst_stall", 32'(if1.STALL_REQ), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
